// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of a five-stage pipeline.  Holds a 4096 x 32-bit data RAM
// addressed by ALU_M[13:2]. Stores merge into the addressed word
// (sw/sh/sb). Loads read the word combinationally and register the
// sign/zero extended result into DMRD_W (lw/lh/lhu/lb/lbu). The M-stage
// bundle (IR, PC, PC+8, ALU result, GRF write enable, Tnew) is then
// registered into the W stage.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en                  stage advance; 0 holds W outputs and blocks stores
//   IR_M, PC_M, PC8_M   M-stage instruction word, address, address + 8
//   ALU_M               ALU result, also the byte address for memory ops
//   RD2_M               store data
//   GRFWE_M, Tnew_M     register-file write enable, cycles until result ready
//   IR_W .. Tnew_W      registered W-stage copies, plus DMRD_W load data
//
// Optional build macro
//   MEM_WRITE_TRACE_EN  print one line per committed store (simulation only)
// ----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] ALU_M,
    input  logic [31:0] RD2_M,
    input  logic        GRFWE_M,
    input  logic [2:0]  Tnew_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic [31:0] PC8_W,
    output logic [31:0] ALU_W,
    output logic [31:0] DMRD_W,
    output logic        GRFWE_W,
    output logic [2:0]  Tnew_W
);

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] PC8_RESET = 32'h0000_3008;

    // Declaration initialisers give power-up values equal to the reset values.
    logic [31:0] mem_q [4096] = '{default: '0};

    logic [31:0] irW_q   = '0;
    logic [31:0] pcW_q   = PC_RESET;
    logic [31:0] pc8W_q  = PC8_RESET;
    logic [31:0] aluW_q  = '0;
    logic [31:0] dmrdW_q = '0;
    logic        weW_q   = 1'b0;
    logic [2:0]  tnewW_q = '0;

    logic [31:0] irW_d, pcW_d, pc8W_d, aluW_d, dmrdW_d;
    logic        weW_d;
    logic [2:0]  tnewW_d;

    logic [5:0]  opcode;
    logic        inRange;
    logic [11:0] wordIdx;
    logic [31:0] rdWord;
    logic [15:0] halfSel;
    logic [7:0]  byteSel;
    logic        isStore;
    logic        storeEn;
    logic [31:0] wrWord;
    logic [31:0] loadData;

    // Address decode and the combinational read of the addressed word.
    always_comb begin
        opcode  = IR_M[31:26];
        inRange = (ALU_M[31:14] == 18'd0);
        wordIdx = ALU_M[13:2];
        rdWord  = mem_q[wordIdx];
        halfSel = ALU_M[1] ? rdWord[31:16] : rdWord[15:0];
        case (ALU_M[1:0])
            2'd0:    byteSel = rdWord[7:0];
            2'd1:    byteSel = rdWord[15:8];
            2'd2:    byteSel = rdWord[23:16];
            default: byteSel = rdWord[31:24];
        endcase
    end

    // Store merge: the new word keeps every lane the store does not touch.
    // storeEn is what actually commits; reset is folded in so the trace
    // logic sees exactly the same condition as the RAM.
    always_comb begin
        isStore = 1'b0;
        wrWord  = rdWord;
        case (opcode)
            OP_SW: begin
                isStore = 1'b1;
                wrWord  = RD2_M;
            end
            OP_SH: begin
                isStore = 1'b1;
                if (ALU_M[1]) wrWord[31:16] = RD2_M[15:0];
                else          wrWord[15:0]  = RD2_M[15:0];
            end
            OP_SB: begin
                isStore = 1'b1;
                case (ALU_M[1:0])
                    2'd0:    wrWord[7:0]   = RD2_M[7:0];
                    2'd1:    wrWord[15:8]  = RD2_M[7:0];
                    2'd2:    wrWord[23:16] = RD2_M[7:0];
                    default: wrWord[31:24] = RD2_M[7:0];
                endcase
            end
            default: ;
        endcase
        storeEn = isStore && en && inRange && !reset;
    end

    // Load extension; non-memory opcodes and out-of-range loads give zero.
    always_comb begin
        loadData = '0;
        if (inRange) begin
            case (opcode)
                OP_LW:  loadData = rdWord;
                OP_LH:  loadData = {{16{halfSel[15]}}, halfSel};
                OP_LHU: loadData = {16'd0, halfSel};
                OP_LB:  loadData = {{24{byteSel[7]}}, byteSel};
                OP_LBU: loadData = {24'd0, byteSel};
                default: loadData = '0;
            endcase
        end
    end

    // Next W-stage state: advance on en, otherwise hold. Tnew saturates at 0.
    always_comb begin
        irW_d   = irW_q;
        pcW_d   = pcW_q;
        pc8W_d  = pc8W_q;
        aluW_d  = aluW_q;
        dmrdW_d = dmrdW_q;
        weW_d   = weW_q;
        tnewW_d = tnewW_q;
        if (en) begin
            irW_d   = IR_M;
            pcW_d   = PC_M;
            pc8W_d  = PC8_M;
            aluW_d  = ALU_M;
            dmrdW_d = loadData;
            weW_d   = GRFWE_M;
            tnewW_d = (Tnew_M == 3'd0) ? 3'd0 : Tnew_M - 3'd1;
        end
    end

    // W-stage pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irW_q   <= '0;
            pcW_q   <= PC_RESET;
            pc8W_q  <= PC8_RESET;
            aluW_q  <= '0;
            dmrdW_q <= '0;
            weW_q   <= 1'b0;
            tnewW_q <= '0;
        end else begin
            irW_q   <= irW_d;
            pcW_q   <= pcW_d;
            pc8W_q  <= pc8W_d;
            aluW_q  <= aluW_d;
            dmrdW_q <= dmrdW_d;
            weW_q   <= weW_d;
            tnewW_q <= tnewW_d;
        end
    end

    // Data RAM. Reset clears every word, so a load after reset reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) begin
                mem_q[i] <= '0;
            end
        end else if (storeEn) begin
            mem_q[wordIdx] <= wrWord;
        end
    end

`ifdef MEM_WRITE_TRACE_EN
    // Store trace: PC, word-aligned address and the full post-write word.
    always @(posedge clk) begin
        if (storeEn) begin
            $display("@%h: *%h <= %h", PC_M, {18'd0, ALU_M[13:2], 2'b00}, wrWord);
        end
    end
`endif

    assign IR_W    = irW_q;
    assign PC_W    = pcW_q;
    assign PC8_W   = pc8W_q;
    assign ALU_W   = aluW_q;
    assign DMRD_W  = dmrdW_q;
    assign GRFWE_W = weW_q;
    assign Tnew_W  = tnewW_q;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Each scenario task drives a few M-stage
// instructions and compares the W-stage outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [31:0] I_SW  = 32'hAC00_0000;
    localparam logic [31:0] I_SH  = 32'hA400_0000;
    localparam logic [31:0] I_SB  = 32'hA000_0000;
    localparam logic [31:0] I_LW  = 32'h8C00_0000;
    localparam logic [31:0] I_LH  = 32'h8400_0000;
    localparam logic [31:0] I_LHU = 32'h9400_0000;
    localparam logic [31:0] I_LB  = 32'h8000_0000;
    localparam logic [31:0] I_LBU = 32'h9000_0000;
    localparam logic [31:0] I_ADD = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] IR_M, PC_M, PC8_M, ALU_M, RD2_M;
    logic        GRFWE_M;
    logic [2:0]  Tnew_M;
    logic [31:0] IR_W, PC_W, PC8_W, ALU_W, DMRD_W;
    logic        GRFWE_W;
    logic [2:0]  Tnew_W;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] pcNext = 32'h0000_3000;
    logic [31:0] lastPc;

    mem_stage dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .IR_M    (IR_M),
        .PC_M    (PC_M),
        .PC8_M   (PC8_M),
        .ALU_M   (ALU_M),
        .RD2_M   (RD2_M),
        .GRFWE_M (GRFWE_M),
        .Tnew_M  (Tnew_M),
        .IR_W    (IR_W),
        .PC_W    (PC_W),
        .PC8_W   (PC8_W),
        .ALU_W   (ALU_W),
        .DMRD_W  (DMRD_W),
        .GRFWE_W (GRFWE_W),
        .Tnew_W  (Tnew_W)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Drive one M-stage instruction, clock it, and settle 1 ns after the edge.
    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] alu,
                                 input logic [31:0] rd2, input logic we,
                                 input logic [2:0] tnew);
        IR_M    = ir;
        ALU_M   = alu;
        RD2_M   = rd2;
        GRFWE_M = we;
        Tnew_M  = tnew;
        PC_M    = pcNext;
        PC8_M   = pcNext + 32'd8;
        lastPc  = pcNext;
        pcNext  = pcNext + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup;
        #1;
        compared++;
        if (PC_W !== 32'h3000 || PC8_W !== 32'h3008 || IR_W !== 32'h0 || DMRD_W !== 32'h0
            || GRFWE_W !== 1'b0 || Tnew_W !== 3'd0 || ALU_W !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL powerup: PC_W=%h PC8_W=%h IR_W=%h DMRD_W=%h ALU_W=%h WE=%b Tnew=%0d",
                     PC_W, PC8_W, IR_W, DMRD_W, ALU_W, GRFWE_W, Tnew_W);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        en    = 1'b1;
        applyStimulus(I_LW, 32'h44, 32'h0, 1'b1, 3'd3);
        compared++;
        if (IR_W !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_ir: got %h want 0", IR_W); end
        compared++;
        if (PC_W !== 32'h3000) begin mismatched++; $display("[TB] FAIL reset_pc: got %h want 00003000", PC_W); end
        compared++;
        if (PC8_W !== 32'h3008) begin mismatched++; $display("[TB] FAIL reset_pc8: got %h want 00003008", PC8_W); end
        compared++;
        if (ALU_W !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_alu: got %h want 0", ALU_W); end
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_dmrd: got %h want 0", DMRD_W); end
        compared++;
        if (GRFWE_W !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b want 0", GRFWE_W); end
        compared++;
        if (Tnew_W !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_tnew: got %0d want 0", Tnew_W); end
        reset = 1'b0;
    endtask

    task automatic test_word;
        applyStimulus(I_SW, 32'h10, 32'h1234_5678, 1'b0, 3'd0);
        compared++;
        if (IR_W !== I_SW || PC_W !== lastPc || PC8_W !== lastPc + 32'd8 || ALU_W !== 32'h10) begin
            mismatched++;
            $display("[TB] FAIL sw_passthru: IR_W=%h PC_W=%h PC8_W=%h ALU_W=%h want %h %h %h 00000010",
                     IR_W, PC_W, PC8_W, ALU_W, I_SW, lastPc, lastPc + 32'd8);
        end
        applyStimulus(I_LW, 32'h10, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL lw_after_sw: got %h want 12345678", DMRD_W); end
        compared++;
        if (GRFWE_W !== 1'b1 || Tnew_W !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL lw_ctrl: WE=%b Tnew=%0d want 1 1", GRFWE_W, Tnew_W);
        end
    endtask

    task automatic test_byte;
        applyStimulus(I_SB, 32'h11, 32'hFFFF_FFAB, 1'b0, 3'd0);
        applyStimulus(I_LBU, 32'h11, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0000_00AB) begin mismatched++; $display("[TB] FAIL lbu: got %h want 000000ab", DMRD_W); end
        applyStimulus(I_LB, 32'h11, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'hFFFF_FFAB) begin mismatched++; $display("[TB] FAIL lb: got %h want ffffffab", DMRD_W); end
        applyStimulus(I_LW, 32'h10, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h1234_AB78) begin mismatched++; $display("[TB] FAIL lw_after_sb: got %h want 1234ab78", DMRD_W); end
        applyStimulus(I_LB, 32'h13, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0000_0012) begin mismatched++; $display("[TB] FAIL lb_lane3: got %h want 00000012", DMRD_W); end
    endtask

    task automatic test_half;
        applyStimulus(I_SH, 32'h22, 32'h7777_8001, 1'b0, 3'd0);
        applyStimulus(I_LH, 32'h22, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'hFFFF_8001) begin mismatched++; $display("[TB] FAIL lh: got %h want ffff8001", DMRD_W); end
        applyStimulus(I_LHU, 32'h22, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0000_8001) begin mismatched++; $display("[TB] FAIL lhu: got %h want 00008001", DMRD_W); end
        applyStimulus(I_LW, 32'h20, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h8001_0000) begin mismatched++; $display("[TB] FAIL lw_after_sh: got %h want 80010000", DMRD_W); end
    endtask

    task automatic test_hold;
        logic [31:0] heldPc;
        applyStimulus(I_LW, 32'h10, 32'h0, 1'b1, 3'd3);
        heldPc = lastPc;
        en = 1'b0;
        applyStimulus(I_SW, 32'h30, 32'hDEAD_BEEF, 1'b0, 3'd5);
        compared++;
        if (IR_W !== I_LW || PC_W !== heldPc || ALU_W !== 32'h10 || DMRD_W !== 32'h1234_AB78
            || GRFWE_W !== 1'b1 || Tnew_W !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL hold: IR_W=%h PC_W=%h ALU_W=%h DMRD_W=%h WE=%b Tnew=%0d want %h %h 00000010 1234ab78 1 2",
                     IR_W, PC_W, ALU_W, DMRD_W, GRFWE_W, Tnew_W, I_LW, heldPc);
        end
        en = 1'b1;
        applyStimulus(I_LW, 32'h30, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL hold_no_store: got %h want 0", DMRD_W); end
    endtask

    task automatic test_tnew;
        applyStimulus(I_ADD, 32'h5, 32'h0, 1'b1, 3'd2);
        compared++;
        if (Tnew_W !== 3'd1) begin mismatched++; $display("[TB] FAIL tnew_2: got %0d want 1", Tnew_W); end
        applyStimulus(I_ADD, 32'h5, 32'h0, 1'b1, 3'd0);
        compared++;
        if (Tnew_W !== 3'd0) begin mismatched++; $display("[TB] FAIL tnew_0: got %0d want 0", Tnew_W); end
        applyStimulus(I_ADD, 32'h5, 32'h0, 1'b0, 3'd7);
        compared++;
        if (Tnew_W !== 3'd6 || GRFWE_W !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL tnew_7: Tnew=%0d WE=%b want 6 0", Tnew_W, GRFWE_W);
        end
    endtask

    task automatic test_nonmem;
        // A non-memory opcode carrying store-like data must leave word 0x10 alone.
        applyStimulus(I_ADD, 32'h10, 32'hFFFF_FFFF, 1'b1, 3'd1);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL nonmem_dmrd: got %h want 0", DMRD_W); end
        applyStimulus(I_LW, 32'h10, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h1234_AB78) begin mismatched++; $display("[TB] FAIL nonmem_no_write: got %h want 1234ab78", DMRD_W); end
        // Aliases word index 4 (0x10) but is out of range.
        applyStimulus(I_LW, 32'h0001_0010, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL lw_out_of_range: got %h want 0", DMRD_W); end
    endtask

    task automatic test_reset_after;
        reset = 1'b1;
        applyStimulus(I_SW, 32'h40, 32'hCAFE_F00D, 1'b1, 3'd4);
        compared++;
        if (IR_W !== 32'h0 || PC_W !== 32'h3000 || PC8_W !== 32'h3008 || ALU_W !== 32'h0
            || DMRD_W !== 32'h0 || GRFWE_W !== 1'b0 || Tnew_W !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_again: IR_W=%h PC_W=%h PC8_W=%h ALU_W=%h DMRD_W=%h WE=%b Tnew=%0d",
                     IR_W, PC_W, PC8_W, ALU_W, DMRD_W, GRFWE_W, Tnew_W);
        end
        reset = 1'b0;
        applyStimulus(I_LW, 32'h10, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL ram_cleared: got %h want 0", DMRD_W); end
        applyStimulus(I_LW, 32'h40, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL store_in_reset: got %h want 0", DMRD_W); end
        applyStimulus(I_SW, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 3'd0);
        applyStimulus(I_LW, 32'h0, 32'h0, 1'b1, 3'd2);
        compared++;
        if (DMRD_W !== 32'h0) begin mismatched++; $display("[TB] FAIL sw_out_of_range: got %h want 0", DMRD_W); end
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b1;
        IR_M    = '0;
        PC_M    = '0;
        PC8_M   = '0;
        ALU_M   = '0;
        RD2_M   = '0;
        GRFWE_M = 1'b0;
        Tnew_M  = '0;
        lastPc  = '0;
        test_powerup();
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_hold();
        test_tnew();
        test_nonmem();
        test_reset_after();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
